// File: rtl/data_mem_pkg.sv
// Shared types and limits for the parametrised data memory and its read pipeline.
package data_mem_pkg;

    typedef enum logic {IDLE, CLEAR} dm_state_t;

    localparam int MAX_RD_LAT = 4;

endpackage

// File: rtl/data_mem_rd_pipe.sv
// Read-return shift pipeline: carries valid, data and range-error flags RD_LAT stages deep.
// Data stages only load when their incoming valid is set, so the last stage holds between reads.
module data_mem_rd_pipe #(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_err,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic              out_err,
    output logic [DATA_W-1:0] out_data
);

    logic [RD_LAT-1:0] valid_q;
    logic [RD_LAT-1:0] err_q;
    logic [RD_LAT-1:0] valid_src;
    logic [RD_LAT-1:0] err_src;
    logic [DATA_W-1:0] data_q   [RD_LAT];
    logic [DATA_W-1:0] data_src [RD_LAT];

    always_comb begin
        valid_src = '0;
        err_src   = '0;
        for (int k = 0; k < RD_LAT; k++) begin
            data_src[k] = '0;
        end
        valid_src[0] = in_valid;
        err_src[0]   = in_err;
        data_src[0]  = in_data;
        for (int k = 1; k < RD_LAT; k++) begin
            valid_src[k] = valid_q[k-1];
            err_src[k]   = err_q[k-1];
            data_src[k]  = data_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_src;
            err_q   <= err_src;
            for (int k = 0; k < RD_LAT; k++) begin
                if (valid_src[k]) begin
                    data_q[k] <= data_src[k];
                end
            end
        end
    end

    assign out_valid = valid_q[RD_LAT-1];
    assign out_err   = err_q[RD_LAT-1];
    assign out_data  = data_q[RD_LAT-1];

endmodule

// File: rtl/data_memory_pipe.sv
// Single-port synchronous data memory with pipelined reads, range checking and a
// sequential zero-fill engine that walks the array one word per cycle.
module data_memory_pipe
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2**ADDR_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ReadMem,
    input  logic              WriteMem,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              clear_req,
    output logic              ready,
    output logic [DATA_W-1:0] DataOut,
    output logic              rd_valid,
    output logic              addr_err,
    output logic              clear_done
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PRE_LAST = PTR_W'(DEPTH - 2);

    if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_rd_lat
        $error("data_memory_pipe: RD_LAT must be within 1..MAX_RD_LAT");
    end
    if (DEPTH < 1 || DEPTH > 2**ADDR_W) begin : g_bad_depth
        $error("data_memory_pipe: DEPTH must be within 1..2**ADDR_W");
    end

    dm_state_t         state_q;
    logic [PTR_W-1:0]  clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range;
    logic [PTR_W-1:0]  idx;
    logic              rd_acc;
    logic              wr_acc;
    logic              acc_err;
    logic [DATA_W-1:0] rd_word;

    assign ready    = (state_q == IDLE);
    assign in_range = ({1'b0, data_addr} < (ADDR_W+1)'(DEPTH));
    assign idx      = data_addr[PTR_W-1:0];
    assign rd_acc   = ReadMem  && ready;
    assign wr_acc   = WriteMem && ready;
    assign acc_err  = (rd_acc || wr_acc) && !in_range;
    // Array is read combinationally here; the old word is captured at the same edge a write lands.
    assign rd_word  = in_range ? mem[idx] : '0;

    // Array has no reset so it can map onto block RAM; clearing shares the single write port.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (wr_acc && in_range) begin
            mem[idx] <= DataIn;
        end
    end

    // clear_done is raised one edge early so it is high while the last word is being written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            clr_ptr    <= '0;
            clear_done <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    clear_done <= 1'b0;
                    if (clear_req) begin
                        state_q    <= CLEAR;
                        clr_ptr    <= '0;
                        clear_done <= (DEPTH == 1);
                    end
                end
                CLEAR: begin
                    if (clr_ptr == LAST_PTR) begin
                        state_q    <= IDLE;
                        clear_done <= 1'b0;
                    end else begin
                        clr_ptr    <= clr_ptr + 1'b1;
                        clear_done <= (clr_ptr == PRE_LAST);
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    clear_done <= 1'b0;
                end
            endcase
        end
    end

    data_mem_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_acc),
        .in_err    (acc_err),
        .in_data   (rd_word),
        .out_valid (rd_valid),
        .out_err   (addr_err),
        .out_data  (DataOut)
    );

endmodule
